maxpool_transfer: RTL and testbench

Drains a finished conv layer's output memory, applies non-overlapping POOL_DIM×POOL_DIM max pooling per channel, and writes the pooled map into the next layer's activation memory. It then pulses the next layer's `compute`. It sits between two layers and acts as the reader of the conv layer's output memory. Values are IEEE-754 doubles, already ReLU'd upstream.

---
 rtl/maxpool_pkg.sv | 36 +++
 rtl/pool_window_counter.sv | 85 ++++++++
 rtl/maxpool_transfer.sv | 171 +++++++++++++++++
 tb/tb_maxpool_transfer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_pkg
//  Description : Shared types, widths and helpers for the max-pool transfer
//                block (state encoding, index width, double max compare).
//  Revision    : 1.0  initial release
// ============================================================================
package maxpool_pkg;

    // Width of every memory index (channel / y / x) on both memory sides.
    localparam int INDEX_W = 16;

    // Width of the IEEE-754 double pattern handled by dbl_max.
    localparam int DBL_W = 64;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } pool_state_t;

    // Larger of two non-negative doubles. For values >= +0.0 the IEEE bit
    // pattern orders the same way as the value, so a plain unsigned compare
    // is exact. On a tie the first argument (the earlier sample) is kept.
    function automatic logic [DBL_W-1:0] dbl_max(
        input logic [DBL_W-1:0] a,
        input logic [DBL_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pool_window_counter
//  Description : Nested ch/oy/ox/ky/kx counter walking every pooling window
//                of every channel. 'step' advances inside a window,
//                'next_window' moves to the next output element.
//  Revision    : 1.0  initial release
// ============================================================================
module pool_window_counter
    import maxpool_pkg::*;
#(
    parameter int NUM_CHANNELS = 1,
    parameter int OUTPUT_DIM   = 2,
    parameter int POOL_DIM     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic               next_window,
    output logic [INDEX_W-1:0] ch,
    output logic [INDEX_W-1:0] oy,
    output logic [INDEX_W-1:0] ox,
    output logic [INDEX_W-1:0] ky,
    output logic [INDEX_W-1:0] kx,
    output logic               win_last,
    output logic               all_last
);

    localparam logic [INDEX_W-1:0] c_CH_LAST = INDEX_W'(NUM_CHANNELS - 1);
    localparam logic [INDEX_W-1:0] c_O_LAST  = INDEX_W'(OUTPUT_DIM - 1);
    localparam logic [INDEX_W-1:0] c_K_LAST  = INDEX_W'(POOL_DIM - 1);

    logic [INDEX_W-1:0] r_ch;
    logic [INDEX_W-1:0] r_oy;
    logic [INDEX_W-1:0] r_ox;
    logic [INDEX_W-1:0] r_ky;
    logic [INDEX_W-1:0] r_kx;

    // Counter update: clear on start, window tap advance, or output advance.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ch <= '0;
            r_oy <= '0;
            r_ox <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else if (next_window) begin
            // Output position advances x fastest, then y, then channel.
            r_ky <= '0;
            r_kx <= '0;
            if (r_ox != c_O_LAST) begin
                r_ox <= r_ox + 1'b1;
            end else begin
                r_ox <= '0;
                if (r_oy != c_O_LAST) begin
                    r_oy <= r_oy + 1'b1;
                end else begin
                    r_oy <= '0;
                    r_ch <= (r_ch != c_CH_LAST) ? r_ch + 1'b1 : '0;
                end
            end
        end else if (step) begin
            if (r_kx != c_K_LAST) begin
                r_kx <= r_kx + 1'b1;
            end else begin
                r_kx <= '0;
                r_ky <= (r_ky != c_K_LAST) ? r_ky + 1'b1 : '0;
            end
        end
    end

    // Status flags and count outputs.
    always_comb begin
        ch       = r_ch;
        oy       = r_oy;
        ox       = r_ox;
        ky       = r_ky;
        kx       = r_kx;
        win_last = (r_kx == c_K_LAST) && (r_ky == c_K_LAST);
        all_last = (r_ch == c_CH_LAST) && (r_oy == c_O_LAST) && (r_ox == c_O_LAST);
    end

endmodule
`default_nettype wire

// File: rtl/maxpool_transfer.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_transfer
//  Description : On a rising edge of src_valid, reads every POOL_DIM x
//                POOL_DIM window of the upstream output memory, writes the
//                window maximum into the next layer's activation memory, then
//                pulses dst_compute / done for one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module maxpool_transfer
    import maxpool_pkg::*;
#(
    parameter string NAME         = "MAXPOOL_TRANSFER_DEFAULT_NAME",
    parameter int    NUM_CHANNELS = 1,
    parameter int    INPUT_DIM    = 4,
    parameter int    POOL_DIM     = 2,
    parameter int    DATA_SIZE    = 64,
    parameter int    OUTPUT_DIM   = INPUT_DIM / POOL_DIM,
    parameter int    DEBUG        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    output logic [INDEX_W-1:0]   src_read_index [2:0],
    input  logic [DATA_SIZE-1:0] src_read_data,
    output logic                 dst_want_write_act,
    output logic [INDEX_W-1:0]   dst_act_index2,
    output logic [INDEX_W-1:0]   dst_act_index1,
    output logic [INDEX_W-1:0]   dst_act_index0,
    output logic [DATA_SIZE-1:0] dst_write_data_act,
    output logic                 dst_compute,
    output logic                 busy,
    output logic                 done
);

    localparam logic [INDEX_W-1:0] c_POOL = INDEX_W'(POOL_DIM);

    pool_state_t          r_state;
    pool_state_t          w_next_state;
    logic                 r_src_valid_q;
    logic [DATA_SIZE-1:0] r_max;

    logic                 w_trigger;
    logic                 w_clear;
    logic                 w_step;
    logic                 w_next_window;
    logic                 w_win_last;
    logic                 w_all_last;
    logic                 w_first_tap;
    logic [INDEX_W-1:0]   w_ch;
    logic [INDEX_W-1:0]   w_oy;
    logic [INDEX_W-1:0]   w_ox;
    logic [INDEX_W-1:0]   w_ky;
    logic [INDEX_W-1:0]   w_kx;
    logic [INDEX_W-1:0]   w_src_y;
    logic [INDEX_W-1:0]   w_src_x;

    // Window / output position walker.
    pool_window_counter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .OUTPUT_DIM   (OUTPUT_DIM),
        .POOL_DIM     (POOL_DIM)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_clear),
        .step        (w_step),
        .next_window (w_next_window),
        .ch          (w_ch),
        .oy          (w_oy),
        .ox          (w_ox),
        .ky          (w_ky),
        .kx          (w_kx),
        .win_last    (w_win_last),
        .all_last    (w_all_last)
    );

    // Source coordinates of the current tap; 16-bit wrap is never reached
    // because OUTPUT_DIM * POOL_DIM <= INPUT_DIM.
    always_comb begin
        w_src_y     = (w_oy * c_POOL) + w_ky;
        w_src_x     = (w_ox * c_POOL) + w_kx;
        w_first_tap = (w_ky == '0) && (w_kx == '0);
        w_trigger   = src_valid && !r_src_valid_q;
    end

    // State register and src_valid history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_src_valid_q <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_src_valid_q <= src_valid;
        end
    end

    // Running window maximum: first tap loads, later taps keep the larger.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
        end else if (r_state == CAPTURE) begin
            r_max <= w_first_tap ? src_read_data : dbl_max(r_max, src_read_data);
        end
    end

    // Next-state decode and all outputs; the read index is held through
    // CAPTURE so both registered and combinational-read memories work.
    always_comb begin
        w_next_state       = r_state;
        w_clear            = 1'b0;
        w_step             = 1'b0;
        w_next_window      = 1'b0;
        src_read_index[2]  = '0;
        src_read_index[1]  = '0;
        src_read_index[0]  = '0;
        dst_want_write_act = 1'b0;
        dst_act_index2     = '0;
        dst_act_index1     = '0;
        dst_act_index0     = '0;
        dst_write_data_act = '0;
        dst_compute        = 1'b0;
        done               = 1'b0;
        busy               = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_clear      = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                src_read_index[2] = w_ch;
                src_read_index[1] = w_src_y;
                src_read_index[0] = w_src_x;
                w_next_state      = CAPTURE;
            end
            CAPTURE: begin
                src_read_index[2] = w_ch;
                src_read_index[1] = w_src_y;
                src_read_index[0] = w_src_x;
                if (w_win_last) begin
                    w_next_state = WRITE;
                end else begin
                    w_step       = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            WRITE: begin
                dst_want_write_act = 1'b1;
                dst_act_index2     = w_ch;
                dst_act_index1     = w_oy;
                dst_act_index0     = w_ox;
                dst_write_data_act = r_max;
                w_next_window      = 1'b1;
                w_next_state       = w_all_last ? DONE : ISSUE;
            end
            DONE: begin
                dst_compute  = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_transfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_transfer
//  Description : Self-checking bench. Instance A: C=1, ID=4, P=2.
//                Instance B: C=2, ID=5, P=2 with random maps checked against
//                a window-maximum model computed on real values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maxpool_transfer;

    localparam int B_C  = 2;
    localparam int B_ID = 5;
    localparam int B_P  = 2;
    localparam int B_OD = B_ID / B_P;
    localparam int B_WRITES  = B_C * B_OD * B_OD;
    localparam int B_LATENCY = 1 + B_WRITES * (2 * B_P * B_P + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic        a_src_valid;
    logic [15:0] a_rd_idx [2:0];
    logic [63:0] a_rd_data;
    logic        a_we, a_comp, a_busy, a_done;
    logic [15:0] a_i2, a_i1, a_i0;
    logic [63:0] a_wd;
    logic [63:0] a_mem [16];
    logic [111:0] a_wq[$];
    int          a_done_cnt = 0;
    int          a_done_cyc = 0;

    maxpool_transfer #(.NUM_CHANNELS(1), .INPUT_DIM(4), .POOL_DIM(2)) dut_a (
        .clk(clk), .rst(rst), .src_valid(a_src_valid),
        .src_read_index(a_rd_idx), .src_read_data(a_rd_data),
        .dst_want_write_act(a_we), .dst_act_index2(a_i2), .dst_act_index1(a_i1),
        .dst_act_index0(a_i0), .dst_write_data_act(a_wd), .dst_compute(a_comp),
        .busy(a_busy), .done(a_done)
    );

    always @(posedge clk) begin
        if (a_rd_idx[1] < 16'd4 && a_rd_idx[0] < 16'd4)
            a_rd_data <= a_mem[int'(a_rd_idx[1]) * 4 + int'(a_rd_idx[0])];
        else
            a_rd_data <= 64'h7FF8_0000_0000_0000;
    end

    always @(negedge clk) begin
        if (a_we) a_wq.push_back({a_i2, a_i1, a_i0, a_wd});
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            a_done_cyc <= cyc;
        end
    end

    // ---------------- instance B ----------------
    logic        b_src_valid;
    logic [15:0] b_rd_idx [2:0];
    logic [63:0] b_rd_data;
    logic        b_we, b_comp, b_busy, b_done;
    logic [15:0] b_i2, b_i1, b_i0;
    logic [63:0] b_wd;
    logic [63:0] b_mem [B_C*B_ID*B_ID];
    logic [111:0] b_wq[$];
    logic [111:0] exp_b[$];
    int          b_done_cnt = 0;
    int          b_comp_cnt = 0;
    int          b_done_cyc = 0;
    int          b_bad_reads = 0;

    maxpool_transfer #(.NUM_CHANNELS(B_C), .INPUT_DIM(B_ID), .POOL_DIM(B_P)) dut_b (
        .clk(clk), .rst(rst), .src_valid(b_src_valid),
        .src_read_index(b_rd_idx), .src_read_data(b_rd_data),
        .dst_want_write_act(b_we), .dst_act_index2(b_i2), .dst_act_index1(b_i1),
        .dst_act_index0(b_i0), .dst_write_data_act(b_wd), .dst_compute(b_comp),
        .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) begin
        if (b_rd_idx[2] < 16'(B_C) && b_rd_idx[1] < 16'(B_ID) && b_rd_idx[0] < 16'(B_ID))
            b_rd_data <= b_mem[int'(b_rd_idx[2]) * B_ID * B_ID + int'(b_rd_idx[1]) * B_ID + int'(b_rd_idx[0])];
        else
            b_rd_data <= 64'h7FF8_0000_0000_0000;
    end

    always @(negedge clk) begin
        if (b_we) b_wq.push_back({b_i2, b_i1, b_i0, b_wd});
        if (b_done) begin
            b_done_cnt <= b_done_cnt + 1;
            b_done_cyc <= cyc;
        end
        if (b_comp) b_comp_cnt <= b_comp_cnt + 1;
        // Taps beyond the pooled area (row/col B_OD*B_P and up) must never be read.
        if (b_rd_idx[2] >= 16'(B_C) || b_rd_idx[1] >= 16'(B_OD * B_P) || b_rd_idx[0] >= 16'(B_OD * B_P))
            b_bad_reads <= b_bad_reads + 1;
    end

    // Expected pooled outputs of instance B in write order (channel, row, col).
    task automatic build_model_b();
        exp_b.delete();
        for (int c = 0; c < B_C; c++)
            for (int oy = 0; oy < B_OD; oy++)
                for (int ox = 0; ox < B_OD; ox++) begin
                    real m = -1.0;
                    for (int ky = 0; ky < B_P; ky++)
                        for (int kx = 0; kx < B_P; kx++) begin
                            real v = $bitstoreal(b_mem[c*B_ID*B_ID + (oy*B_P+ky)*B_ID + ox*B_P+kx]);
                            if (v > m) m = v;
                        end
                    exp_b.push_back({16'(c), 16'(oy), 16'(ox), $realtobits(m)});
                end
    endtask

    task automatic fill_random_b();
        for (int i = 0; i < B_C*B_ID*B_ID; i++)
            if ($urandom_range(0, 3) == 0) b_mem[i] = 64'h0;
            else b_mem[i] = $realtobits(real'($urandom_range(1, 100000)) / 8.0);
    endtask

    // Raise B's src_valid; start is the cycle in which it is first high.
    task automatic start_b(output int start);
        @(negedge clk);
        b_src_valid = 1'b1;
        start = cyc;
    endtask

    task automatic wait_b_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (b_done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_src_valid = 1'b0;
        b_src_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", b_busy); end
        checks++; if (b_done !== 1'b0 || b_comp !== 1'b0) begin failures++; $display("FAIL reset_done got %b/%b want 0/0", b_done, b_comp); end
        checks++; if (b_we !== 1'b0 || b_wd !== 64'h0) begin failures++; $display("FAIL reset_write got %b/%h want 0/0", b_we, b_wd); end
        checks++; if ({b_rd_idx[2], b_rd_idx[1], b_rd_idx[0]} !== 48'h0) begin failures++; $display("FAIL reset_rdidx got %h want 0", {b_rd_idx[2], b_rd_idx[1], b_rd_idx[0]}); end
        checks++; if ({b_i2, b_i1, b_i0} !== 48'h0) begin failures++; $display("FAIL reset_wridx got %h want 0", {b_i2, b_i1, b_i0}); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_a_busy got %b want 0", a_busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [111:0] want [4];
        int start, base, wb;
        bit ok;
        want[0] = {16'd0, 16'd0, 16'd0, $realtobits(5.0)};
        want[1] = {16'd0, 16'd0, 16'd1, $realtobits(7.0)};
        want[2] = {16'd0, 16'd1, 16'd0, $realtobits(13.0)};
        want[3] = {16'd0, 16'd1, 16'd1, $realtobits(15.0)};
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                a_mem[y*4+x] = $realtobits(real'(x + 4*y));
        base = a_done_cnt;
        wb = a_wq.size();
        @(negedge clk);
        a_src_valid = 1'b1;
        start = cyc;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (a_done_cnt > base) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (a_done_cyc - start !== 37) begin failures++; $display("FAIL basic_latency got %0d want 37", a_done_cyc - start); end
        checks++; if (a_wq.size() - wb !== 4) begin failures++; $display("FAIL basic_count got %0d want 4", a_wq.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_wq.size() <= wb + i) begin failures++; $display("FAIL basic_write%0d got none want %h", i, want[i]); end
            else if (a_wq[wb+i] !== want[i]) begin failures++; $display("FAIL basic_write%0d got %h want %h", i, a_wq[wb+i], want[i]); end
        end
        @(negedge clk);
        a_src_valid = 1'b0;
    endtask

    task automatic test_channels();
        int start, base, wb, rb;
        bit ok;
        for (int c = 0; c < B_C; c++)
            for (int y = 0; y < B_ID; y++)
                for (int x = 0; x < B_ID; x++)
                    b_mem[c*B_ID*B_ID + y*B_ID + x] = (y == 4 || x == 4) ? $realtobits(1.0e9)
                                                     : $realtobits(real'(x + B_ID*y + 100*c));
        build_model_b();
        base = b_done_cnt; wb = b_wq.size(); rb = b_bad_reads;
        start_b(start);
        wait_b_done(base, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL chan_timeout got no done want done"); end
        checks++; if (b_done_cyc - start !== B_LATENCY) begin failures++; $display("FAIL chan_latency got %0d want %0d", b_done_cyc - start, B_LATENCY); end
        checks++; if (b_wq.size() - wb !== B_WRITES) begin failures++; $display("FAIL chan_count got %0d want %0d", b_wq.size() - wb, B_WRITES); end
        checks++; if (b_wq.size() > wb && b_wq[wb][63:0] !== 64'h4018_0000_0000_0000) begin failures++; $display("FAIL chan_first got %h want 4018000000000000", b_wq[wb][63:0]); end
        for (int i = 0; i < B_WRITES; i++) begin
            checks++;
            if (b_wq.size() <= wb + i) begin failures++; $display("FAIL chan_write%0d got none want %h", i, exp_b[i]); end
            else if (b_wq[wb+i] !== exp_b[i]) begin failures++; $display("FAIL chan_write%0d got %h want %h", i, b_wq[wb+i], exp_b[i]); end
        end
        checks++; if (b_bad_reads !== rb) begin failures++; $display("FAIL chan_outside_reads got %0d want 0", b_bad_reads - rb); end
        @(negedge clk);
        b_src_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int start, base, wb;
        bit ok;
        for (int it = 0; it < 3; it++) begin
            fill_random_b();
            build_model_b();
            base = b_done_cnt; wb = b_wq.size();
            start_b(start);
            wait_b_done(base, 400, ok);
            checks++; if (!ok || b_done_cyc - start !== B_LATENCY) begin failures++; $display("FAIL rand%0d_latency got %0d want %0d", it, b_done_cyc - start, B_LATENCY); end
            checks++; if (b_wq.size() - wb !== B_WRITES) begin failures++; $display("FAIL rand%0d_count got %0d want %0d", it, b_wq.size() - wb, B_WRITES); end
            for (int i = 0; i < B_WRITES; i++) begin
                checks++;
                if (b_wq.size() <= wb + i) begin failures++; $display("FAIL rand%0d_write%0d got none want %h", it, i, exp_b[i]); end
                else if (b_wq[wb+i] !== exp_b[i]) begin failures++; $display("FAIL rand%0d_write%0d got %h want %h", it, i, b_wq[wb+i], exp_b[i]); end
            end
            @(negedge clk);
            b_src_valid = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_zero();
        int start, base, cb, wb;
        bit ok;
        for (int i = 0; i < B_C*B_ID*B_ID; i++) b_mem[i] = 64'h0;
        base = b_done_cnt; cb = b_comp_cnt; wb = b_wq.size();
        start_b(start);
        wait_b_done(base, 400, ok);
        repeat (5) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL zero_timeout got no done want done"); end
        checks++; if (b_comp_cnt - cb !== 1) begin failures++; $display("FAIL zero_compute got %0d pulses want 1", b_comp_cnt - cb); end
        checks++; if (b_wq.size() - wb !== B_WRITES) begin failures++; $display("FAIL zero_count got %0d want %0d", b_wq.size() - wb, B_WRITES); end
        for (int i = wb; i < b_wq.size(); i++) begin
            checks++;
            if (b_wq[i][63:0] !== 64'h0) begin failures++; $display("FAIL zero_data%0d got %h want 0", i - wb, b_wq[i][63:0]); end
        end
        b_src_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_held_high();
        int start, base, wb;
        bit ok;
        fill_random_b();
        build_model_b();
        base = b_done_cnt; wb = b_wq.size();
        start_b(start);
        wait_b_done(base, 400, ok);
        repeat (200) @(negedge clk);
        #1;
        checks++; if (!ok || b_done_cnt - base !== 1) begin failures++; $display("FAIL held_done got %0d want 1", b_done_cnt - base); end
        checks++; if (b_wq.size() - wb !== B_WRITES) begin failures++; $display("FAIL held_count got %0d want %0d", b_wq.size() - wb, B_WRITES); end
        b_src_valid = 1'b0;
        repeat (3) @(negedge clk);
        base = b_done_cnt; wb = b_wq.size();
        start_b(start);
        wait_b_done(base, 400, ok);
        checks++; if (!ok || b_done_cyc - start !== B_LATENCY) begin failures++; $display("FAIL held_second_latency got %0d want %0d", b_done_cyc - start, B_LATENCY); end
        for (int i = 0; i < B_WRITES; i++) begin
            checks++;
            if (b_wq.size() <= wb + i) begin failures++; $display("FAIL held_write%0d got none want %h", i, exp_b[i]); end
            else if (b_wq[wb+i] !== exp_b[i]) begin failures++; $display("FAIL held_write%0d got %h want %h", i, b_wq[wb+i], exp_b[i]); end
        end
        @(negedge clk);
        b_src_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int start, base, wb;
        bit ok;
        fill_random_b();
        build_model_b();
        base = b_done_cnt;
        start_b(start);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        b_src_valid = 1'b0;
        @(negedge clk);
        #1;
        wb = b_wq.size();
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", b_busy); end
        checks++; if (b_we !== 1'b0 || b_done !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got we=%b done=%b want 0/0", b_we, b_done); end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        checks++; if (b_wq.size() !== wb) begin failures++; $display("FAIL rstmid_writes got %0d extra want 0", b_wq.size() - wb); end
        checks++; if (b_done_cnt !== base) begin failures++; $display("FAIL rstmid_done got %0d pulses want 0", b_done_cnt - base); end
        start_b(start);
        wait_b_done(base, 400, ok);
        checks++; if (!ok || b_done_cyc - start !== B_LATENCY) begin failures++; $display("FAIL rstmid_rerun_latency got %0d want %0d", b_done_cyc - start, B_LATENCY); end
        for (int i = 0; i < B_WRITES; i++) begin
            checks++;
            if (b_wq.size() <= wb + i) begin failures++; $display("FAIL rstmid_write%0d got none want %h", i, exp_b[i]); end
            else if (b_wq[wb+i] !== exp_b[i]) begin failures++; $display("FAIL rstmid_write%0d got %h want %h", i, b_wq[wb+i], exp_b[i]); end
        end
        @(negedge clk);
        b_src_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_toggle_busy();
        int start, base, wb;
        bit ok;
        fill_random_b();
        build_model_b();
        base = b_done_cnt; wb = b_wq.size();
        start_b(start);
        repeat (20) @(negedge clk);
        b_src_valid = 1'b0;
        repeat (3) @(negedge clk);
        b_src_valid = 1'b1;
        wait_b_done(base, 400, ok);
        checks++; if (!ok || b_done_cyc - start !== B_LATENCY) begin failures++; $display("FAIL toggle_latency got %0d want %0d", b_done_cyc - start, B_LATENCY); end
        repeat (100) @(negedge clk);
        #1;
        checks++; if (b_done_cnt - base !== 1) begin failures++; $display("FAIL toggle_done got %0d want 1", b_done_cnt - base); end
        checks++; if (b_wq.size() - wb !== B_WRITES) begin failures++; $display("FAIL toggle_count got %0d want %0d", b_wq.size() - wb, B_WRITES); end
        for (int i = 0; i < B_WRITES; i++) begin
            checks++;
            if (b_wq.size() <= wb + i) begin failures++; $display("FAIL toggle_write%0d got none want %h", i, exp_b[i]); end
            else if (b_wq[wb+i] !== exp_b[i]) begin failures++; $display("FAIL toggle_write%0d got %h want %h", i, b_wq[wb+i], exp_b[i]); end
        end
        b_src_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channels();
        test_random();
        test_zero();
        test_held_high();
        test_reset_mid();
        test_toggle_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
